// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types, plus the condition-code type, its reset value
// and the NZP generator used by the register file.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_nzp;
  typedef logic [1:0]  lc3b_mem_wmask;
  typedef lc3b_nzp     lc3b_cc_t;

  localparam lc3b_cc_t CC_RESET = 3'b010;

  // Width-independent core: callers supply the sign bit and the zero flag.
  function automatic lc3b_cc_t gen_cc_flags(input logic sign, input logic zero);
    lc3b_cc_t cc;
    if (zero) begin
      cc = 3'b010;
    end else if (sign) begin
      cc = 3'b100;
    end else begin
      cc = 3'b001;
    end
    return cc;
  endfunction

  function automatic lc3b_cc_t gen_cc(input lc3b_word word);
    return gen_cc_flags(word[15], word == 16'h0000);
  endfunction

endpackage

// File: rtl/lc3b_byte_merge.sv
// Combinational byte-lane merge: each lane takes the new data when its mask
// bit is set and keeps the old data otherwise.
module lc3b_byte_merge
  import lc3b_types::*;
#(
  parameter int NBYTES = 2
) (
  input  logic [NBYTES*8-1:0] i_old,
  input  logic [NBYTES*8-1:0] i_new,
  input  logic [NBYTES-1:0]   i_mask,
  output logic [NBYTES*8-1:0] o_merged
);

  for (genvar b = 0; b < NBYTES; b++) begin : g_lane
    assign o_merged[8*b +: 8] = i_mask[b] ? i_new[8*b +: 8] : i_old[8*b +: 8];
  end

endmodule

// File: rtl/lc3b_regfile_cc.sv
// Parametrised register file with byte-masked writes, write-to-read bypass,
// an NZP condition-code register and branch-enable evaluation.
module lc3b_regfile_cc
  import lc3b_types::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int NREGS  = 8,
  parameter  int NREAD  = 2,
  localparam int IDXW   = $clog2(NREGS),
  localparam int NBYTES = WIDTH / 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we,
  input  logic [IDXW-1:0]             wr_idx,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic [NBYTES-1:0]           wr_mask,
  input  logic                        cc_ld,
  input  logic [NREAD-1:0][IDXW-1:0]  rd_idx,
  output logic [NREAD-1:0][WIDTH-1:0] rd_data,
  input  logic [2:0]                  br_nzp,
  output logic [2:0]                  cc_out,
  output logic                        br_enable
);

  logic [WIDTH-1:0] r_regs [NREGS];
  lc3b_cc_t         r_cc;
  logic [WIDTH-1:0] w_merged;
  lc3b_cc_t         w_cc_next;

  // One merge serves the array write, the read bypass and the CC generator.
  lc3b_byte_merge #(
    .NBYTES (NBYTES)
  ) u_merge (
    .i_old    (r_regs[wr_idx]),
    .i_new    (wr_data),
    .i_mask   (wr_mask),
    .o_merged (w_merged)
  );

  assign w_cc_next = gen_cc_flags(w_merged[WIDTH-1], w_merged == {WIDTH{1'b0}});

  // Register array and CC update; reset overrides any write in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        r_regs[r] <= {WIDTH{1'b0}};
      end
      r_cc <= CC_RESET;
    end else begin
      if (we) begin
        r_regs[wr_idx] <= w_merged;
      end
      if (we && cc_ld) begin
        r_cc <= w_cc_next;
      end
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    assign rd_data[i] = (we && (rd_idx[i] == wr_idx)) ? w_merged : r_regs[rd_idx[i]];
  end

  // Branch sees only the registered CC; a pending cc_ld is not forwarded.
  assign cc_out    = r_cc;
  assign br_enable = |(br_nzp & r_cc);

endmodule

// File: tb/tb_lc3b_regfile_cc.sv
// Directed and randomized checks of lc3b_regfile_cc against a behavioural
// model, on the default 16x8 / 2-port build and a 32x16 / 3-port build.
module tb_lc3b_regfile_cc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Default build: WIDTH=16, NREGS=8, NREAD=2
  logic             a_rst_n, a_we, a_cc_ld, a_br_en;
  logic [2:0]       a_wr_idx, a_br_nzp, a_cc_out;
  logic [15:0]      a_wr_data;
  logic [1:0]       a_wr_mask;
  logic [1:0][2:0]  a_rd_idx;
  logic [1:0][15:0] a_rd_data;

  // Wide build: WIDTH=32, NREGS=16, NREAD=3
  logic             b_rst_n, b_we, b_cc_ld, b_br_en;
  logic [3:0]       b_wr_idx;
  logic [2:0]       b_br_nzp, b_cc_out;
  logic [31:0]      b_wr_data;
  logic [3:0]       b_wr_mask;
  logic [2:0][3:0]  b_rd_idx;
  logic [2:0][31:0] b_rd_data;

  lc3b_regfile_cc dut_a (
    .clk(clk), .rst_n(a_rst_n), .we(a_we), .wr_idx(a_wr_idx), .wr_data(a_wr_data),
    .wr_mask(a_wr_mask), .cc_ld(a_cc_ld), .rd_idx(a_rd_idx), .rd_data(a_rd_data),
    .br_nzp(a_br_nzp), .cc_out(a_cc_out), .br_enable(a_br_en)
  );

  lc3b_regfile_cc #(.WIDTH(32), .NREGS(16), .NREAD(3)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .we(b_we), .wr_idx(b_wr_idx), .wr_data(b_wr_data),
    .wr_mask(b_wr_mask), .cc_ld(b_cc_ld), .rd_idx(b_rd_idx), .rd_data(b_rd_data),
    .br_nzp(b_br_nzp), .cc_out(b_cc_out), .br_enable(b_br_en)
  );

  logic [15:0] ma [8];
  logic [2:0]  mcc_a;
  logic [31:0] mb [16];
  logic [2:0]  mcc_b;

  function automatic logic [63:0] ref_merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                            input logic [7:0] mask, input int nb);
    logic [63:0] res;
    res = old_v;
    for (int b = 0; b < nb; b++) begin
      if (mask[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic [2:0] ref_cc(input logic [63:0] v, input int w);
    if (v == 64'd0) return 3'b010;
    else if (v[w-1]) return 3'b100;
    else return 3'b001;
  endfunction

  function automatic logic ref_br(input logic [2:0] nzp, input logic [2:0] cc);
    return (nzp[2] && cc[2]) || (nzp[1] && cc[1]) || (nzp[0] && cc[0]);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag);
    logic [15:0] merged;
    logic [15:0] exp;
    #1;
    merged = 16'(ref_merge({48'd0, ma[a_wr_idx]}, {48'd0, a_wr_data}, {6'd0, a_wr_mask}, 2));
    for (int p = 0; p < 2; p++) begin
      exp = (a_we && a_rd_idx[p] == a_wr_idx) ? merged : ma[a_rd_idx[p]];
      chk($sformatf("%s_rd%0d", tag, p), {48'd0, a_rd_data[p]}, {48'd0, exp});
    end
    chk({tag, "_cc"}, {61'd0, a_cc_out}, {61'd0, mcc_a});
    chk({tag, "_br"}, {63'd0, a_br_en}, {63'd0, ref_br(a_br_nzp, mcc_a)});
  endtask

  task automatic tick_a();
    logic [15:0] merged;
    merged = 16'(ref_merge({48'd0, ma[a_wr_idx]}, {48'd0, a_wr_data}, {6'd0, a_wr_mask}, 2));
    @(posedge clk);
    if (!a_rst_n) begin
      for (int r = 0; r < 8; r++) ma[r] = 16'd0;
      mcc_a = 3'b010;
    end else begin
      if (a_we) ma[a_wr_idx] = merged;
      if (a_we && a_cc_ld) mcc_a = ref_cc({48'd0, merged}, 16);
    end
    #1;
  endtask

  task automatic drive_a(input logic we, input logic [2:0] idx, input logic [15:0] data,
                         input logic [1:0] mask, input logic ccld);
    a_we = we; a_wr_idx = idx; a_wr_data = data; a_wr_mask = mask; a_cc_ld = ccld;
  endtask

  initial begin
    a_rst_n = 1'b0; a_br_nzp = 3'b000; a_rd_idx = '0;
    drive_a(1'b0, 3'd0, 16'd0, 2'b00, 1'b0);
    b_rst_n = 1'b1; b_we = 1'b0; b_wr_idx = 4'd0; b_wr_data = 32'd0; b_wr_mask = 4'd0;
    b_cc_ld = 1'b0; b_rd_idx = '0; b_br_nzp = 3'b000;
    for (int r = 0; r < 8; r++) ma[r] = 16'hxxxx;
    mcc_a = 3'bxxx;
    #1;
    tick_a();
    a_rst_n = 1'b1;

    // 1. reset contents on every port
    a_br_nzp = 3'b010;
    for (int r = 0; r < 8; r++) begin
      a_rd_idx[0] = 3'(r); a_rd_idx[1] = 3'(7 - r);
      check_a("t1_reset");
    end
    chk("t1_br_z", {63'd0, a_br_en}, 64'd1);

    // 2. bypass of a full-width write, then CC becomes N
    a_rd_idx[0] = 3'd3;
    drive_a(1'b1, 3'd3, 16'h8001, 2'b11, 1'b1);
    check_a("t2_wr");
    chk("t2_bypass", {48'd0, a_rd_data[0]}, 64'h8001);
    tick_a();
    drive_a(1'b0, 3'd0, 16'd0, 2'b00, 1'b0);
    check_a("t2_after");
    chk("t2_r3", {48'd0, a_rd_data[0]}, 64'h8001);
    chk("t2_cc", {61'd0, a_cc_out}, 64'h4);

    // 3. low-byte write, then an all-lanes-off write with cc_ld
    drive_a(1'b1, 3'd5, 16'h1234, 2'b11, 1'b0); tick_a();
    drive_a(1'b1, 3'd5, 16'hABFF, 2'b01, 1'b1); tick_a();
    drive_a(1'b0, 3'd0, 16'd0, 2'b00, 1'b0);
    a_rd_idx[0] = 3'd5; a_rd_idx[1] = 3'd5;
    check_a("t3_lo");
    chk("t3_r5", {48'd0, a_rd_data[1]}, 64'h12FF);
    chk("t3_cc", {61'd0, a_cc_out}, 64'h1);
    drive_a(1'b1, 3'd5, 16'hFFFF, 2'b00, 1'b1); tick_a();
    drive_a(1'b0, 3'd0, 16'd0, 2'b00, 1'b0);
    check_a("t3_nomask");
    chk("t3_r5_keep", {48'd0, a_rd_data[0]}, 64'h12FF);
    chk("t3_cc_keep", {61'd0, a_cc_out}, 64'h1);

    // 4. CC change is not forwarded to br_enable
    a_br_nzp = 3'b010;
    drive_a(1'b1, 3'd2, 16'h0000, 2'b11, 1'b1);
    check_a("t4_same");
    chk("t4_br_old", {63'd0, a_br_en}, 64'd0);
    tick_a();
    drive_a(1'b0, 3'd0, 16'd0, 2'b00, 1'b0);
    check_a("t4_next");
    chk("t4_br_new", {63'd0, a_br_en}, 64'd1);
    a_br_nzp = 3'b000; #1; chk("t4_br_000", {63'd0, a_br_en}, 64'd0);
    a_br_nzp = 3'b111; #1; chk("t4_br_111", {63'd0, a_br_en}, 64'd1);

    // 5. reset wins over a simultaneous write
    a_rst_n = 1'b0;
    drive_a(1'b1, 3'd1, 16'hFFFF, 2'b11, 1'b1);
    tick_a();
    a_rst_n = 1'b1;
    drive_a(1'b0, 3'd0, 16'd0, 2'b00, 1'b0);
    a_rd_idx[0] = 3'd1; a_rd_idx[1] = 3'd3;
    check_a("t5_rst");
    chk("t5_r1", {48'd0, a_rd_data[0]}, 64'd0);
    chk("t5_cc", {61'd0, a_cc_out}, 64'h2);

    // random traffic against the model
    for (int it = 0; it < 300; it++) begin
      a_rst_n = ($urandom_range(0, 39) != 0);
      drive_a(1'($urandom), 3'($urandom), 16'($urandom), 2'($urandom), 1'($urandom));
      if ($urandom_range(0, 7) == 0) a_wr_data = 16'h0000;
      a_rd_idx[0] = $urandom_range(0, 3) == 0 ? a_wr_idx : 3'($urandom);
      a_rd_idx[1] = 3'($urandom);
      a_br_nzp = 3'($urandom);
      check_a("rnd");
      tick_a();
    end
    a_rst_n = 1'b1;
    drive_a(1'b0, 3'd0, 16'd0, 2'b00, 1'b0);

    // 6. wide build: three ports read a zeroed R15, CC back to Z
    b_rst_n = 1'b0; @(posedge clk); #1; b_rst_n = 1'b1;
    for (int r = 0; r < 16; r++) mb[r] = 32'd0;
    mcc_b = 3'b010;
    b_we = 1'b1; b_wr_idx = 4'd15; b_wr_data = 32'h0000_5A00; b_wr_mask = 4'b0010; b_cc_ld = 1'b1;
    @(posedge clk); #1;
    mb[15] = 32'(ref_merge({32'd0, mb[15]}, {32'd0, b_wr_data}, {4'd0, b_wr_mask}, 4));
    mcc_b = ref_cc({32'd0, mb[15]}, 32);
    b_we = 1'b0; b_rd_idx[0] = 4'd15; #1;
    chk("t6_pre_r15", {32'd0, b_rd_data[0]}, {32'd0, mb[15]});
    chk("t6_pre_cc", {61'd0, b_cc_out}, {61'd0, mcc_b});
    b_we = 1'b1; b_wr_data = 32'h0000_0000; b_wr_mask = 4'b1111; b_cc_ld = 1'b1;
    @(posedge clk); #1;
    b_we = 1'b0; b_cc_ld = 1'b0;
    b_rd_idx[0] = 4'd15; b_rd_idx[1] = 4'd15; b_rd_idx[2] = 4'd15;
    b_br_nzp = 3'b010; #1;
    for (int p = 0; p < 3; p++) chk($sformatf("t6_rd%0d", p), {32'd0, b_rd_data[p]}, 64'd0);
    chk("t6_cc", {61'd0, b_cc_out}, 64'h2);
    chk("t6_br", {63'd0, b_br_en}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
